// File: rtl/note_lane_scheduler.sv
// rtl/note_lane_scheduler.sv - per-lane chart sequencer: song frame clock, note spawns, key judgement
module note_lane_scheduler #(
   parameter int NOTE_COUNT  = 121,
   parameter int LEAD_FRAMES = 60,
   parameter int PERFECT_WIN = 3,
   parameter int GOOD_WIN    = 6,
   parameter int MAX_SPAWN   = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic        frame_tick,
   input  logic        key_down,
   output logic [7:0]  rom_addr,
   input  logic [15:0] key_1,
   input  logic [15:0] key_2,
   input  logic [15:0] key_3,
   input  logic [15:0] key_4,
   output logic        spawn_valid,
   input  logic        spawn_ready,
   output logic [1:0]  spawn_type,
   output logic [13:0] spawn_time,
   output logic        judge_valid,
   output logic [1:0]  judge_code,
   output logic        hold_active,
   output logic [13:0] song_time,
   output logic        done
);

   localparam logic [7:0]         NOTE_MAX  = 8'(NOTE_COUNT);
   localparam logic [14:0]        LEAD      = 15'(LEAD_FRAMES);
   localparam logic signed [14:0] PWIN      = 15'(PERFECT_WIN);
   localparam logic signed [14:0] GWIN      = 15'(GOOD_WIN);
   localparam logic [2:0]         SPAWN_MAX = 3'(MAX_SPAWN);
   localparam logic [1:0]         J_MISS    = 2'b00;
   localparam logic [1:0]         J_GOOD    = 2'b01;
   localparam logic [1:0]         J_PERFECT = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADV, S_SP_RD, S_SP_OUT, S_JG_RD, S_JUDGE, S_DONE} state_t;

   state_t             state, state_nx;
   logic [7:0]         spawn_ptr, judge_ptr, judge_ptr_nx;
   logic [15:0]        ent;
   logic [2:0]         spawn_cnt;
   logic               key_q, press_pend, release_pend, tick_pend, skip_hold;
   logic               j_adv, hold_set, hold_clr, skip_set, skip_clr;
   logic               press_edge, release_edge, keys_live;
   logic [14:0]        lead_sum;
   logic               spawn_due;
   logic signed [14:0] d;
   logic               in_perfect, in_good, is_late;
   logic               unused_keys;

   // Only the first ROM lane belongs to this block.
   assign unused_keys = ^{key_2, key_3, key_4};

   assign lead_sum   = {1'b0, song_time} + LEAD;
   assign spawn_due  = (spawn_ptr < NOTE_MAX) && ({1'b0, ent[13:0]} <= lead_sum) && (spawn_cnt < SPAWN_MAX);
   assign d          = {1'b0, ent[13:0]} - {1'b0, song_time};
   assign in_perfect = (d >= -PWIN) && (d <= PWIN);
   assign in_good    = (d >= -GWIN) && (d <= GWIN);
   assign is_late    = (d < -GWIN);

   assign keys_live    = (state != S_IDLE) && (state != S_DONE);
   assign press_edge   = keys_live && key_down && !key_q;
   assign release_edge = keys_live && !key_down && key_q;
   assign done         = (state == S_DONE);

   // Next state, ROM address, spawn handshake and judgement decision.
   always_comb begin
      state_nx     = state;
      rom_addr     = 8'd0;
      spawn_valid  = 1'b0;
      spawn_type   = 2'b00;
      spawn_time   = 14'd0;
      judge_valid  = 1'b0;
      judge_code   = J_MISS;
      j_adv        = 1'b0;
      hold_set     = 1'b0;
      hold_clr     = 1'b0;
      skip_set     = 1'b0;
      skip_clr     = 1'b0;
      judge_ptr_nx = judge_ptr;
      case (state)
         S_IDLE:  if (start) state_nx = S_WAIT;
         S_WAIT:  if (frame_tick || tick_pend) state_nx = S_ADV;
         S_ADV:   state_nx = S_SP_RD;
         S_SP_RD: begin
            rom_addr = spawn_ptr;
            state_nx = S_SP_OUT;
         end
         S_SP_OUT: begin
            if (spawn_due) begin
               spawn_valid = 1'b1;
               spawn_type  = ent[15:14];
               spawn_time  = ent[13:0];
               if (spawn_ready) state_nx = S_SP_RD;
            end else begin
               state_nx = S_JG_RD;
            end
         end
         S_JG_RD: begin
            rom_addr = judge_ptr;
            state_nx = S_JUDGE;
         end
         S_JUDGE: begin
            if (judge_ptr < NOTE_MAX) begin
               case (ent[15:14])
                  2'b00, 2'b01: begin
                     if (press_pend && in_good) begin
                        judge_valid = 1'b1;
                        judge_code  = in_perfect ? J_PERFECT : J_GOOD;
                        j_adv       = 1'b1;
                        hold_set    = ent[14];
                     end else if (is_late) begin
                        judge_valid = 1'b1;
                        j_adv       = 1'b1;
                        skip_set    = ent[14];
                     end
                  end
                  2'b10: begin
                     if (skip_hold) begin
                        judge_valid = 1'b1;
                        j_adv       = 1'b1;
                        skip_clr    = 1'b1;
                     end else if (hold_active) begin
                        if ((d <= 15'sd0) && key_down) begin
                           judge_valid = 1'b1;
                           judge_code  = J_PERFECT;
                        end else if (release_pend) begin
                           judge_valid = 1'b1;
                           judge_code  = (d <= GWIN) ? J_GOOD : J_MISS;
                        end
                        j_adv    = judge_valid;
                        hold_clr = judge_valid;
                     end else if (is_late) begin
                        judge_valid = 1'b1;
                        j_adv       = 1'b1;
                     end
                  end
                  default: j_adv = 1'b1;
               endcase
            end
            judge_ptr_nx = judge_ptr + 8'(j_adv);
            state_nx     = (judge_ptr_nx == NOTE_MAX) ? S_DONE : S_WAIT;
         end
         S_DONE:  state_nx = S_DONE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State, song clock, chart pointers, hold tracking and pending key/tick flags.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= S_IDLE;
         song_time    <= 14'd0;
         spawn_ptr    <= 8'd0;
         judge_ptr    <= 8'd0;
         ent          <= 16'd0;
         spawn_cnt    <= 3'd0;
         key_q        <= 1'b0;
         press_pend   <= 1'b0;
         release_pend <= 1'b0;
         tick_pend    <= 1'b0;
         hold_active  <= 1'b0;
         skip_hold    <= 1'b0;
      end else begin
         state     <= state_nx;
         key_q     <= key_down;
         judge_ptr <= judge_ptr_nx;
         if (state == S_ADV) begin
            song_time <= (song_time == 14'h3FFF) ? song_time : song_time + 14'd1;
            spawn_cnt <= 3'd0;
         end else if (spawn_valid && spawn_ready) begin
            spawn_cnt <= spawn_cnt + 3'd1;
         end
         if (spawn_valid && spawn_ready) spawn_ptr <= spawn_ptr + 8'd1;
         if ((state == S_SP_RD) || (state == S_JG_RD)) ent <= key_1;
         hold_active  <= (hold_active | hold_set) & ~hold_clr;
         skip_hold    <= (skip_hold | skip_set) & ~skip_clr;
         // An edge arriving during the judge cycle itself survives into the next frame.
         press_pend   <= ((state == S_JUDGE) ? 1'b0 : press_pend) | press_edge;
         release_pend <= ((state == S_JUDGE) ? 1'b0 : release_pend) | release_edge;
         // One tick may wait while the frame is busy; a live tick seen in WAIT keeps a pending one queued.
         if (state == S_WAIT) tick_pend <= tick_pend & frame_tick;
         else if (keys_live && frame_tick) tick_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_note_lane_scheduler.sv
// tb/tb_note_lane_scheduler.sv - directed self-checking bench for note_lane_scheduler
module tb_note_lane_scheduler;

   logic        Clk = 1'b0;
   logic        Reset, start, frame_tick, key_down, spawn_ready;
   logic [15:0] chart [0:255];

   logic [7:0]  rom_addr, rom_addr1;
   logic [15:0] key_1, key_1b;
   logic        spawn_valid, judge_valid, hold_active, done;
   logic [1:0]  spawn_type, judge_code;
   logic [13:0] spawn_time, song_time;
   logic        spawn_valid1, judge_valid1, hold_active1, done1;
   logic [1:0]  spawn_type1, judge_code1;
   logic [13:0] spawn_time1, song_time1;

   int n_checks = 0;
   int n_pass   = 0;

   int          f_spawns, r_spawns, r_judges;
   logic        f_jv;
   logic [1:0]  f_jc, f_sty;
   logic [13:0] f_js, f_st, f_ss;
   logic        seen;

   always #5 Clk = ~Clk;

   assign key_1  = chart[rom_addr];
   assign key_1b = chart[rom_addr1];

   note_lane_scheduler #(.NOTE_COUNT(8)) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .frame_tick(frame_tick), .key_down(key_down),
      .rom_addr(rom_addr), .key_1(key_1), .key_2(16'd0), .key_3(16'd0), .key_4(16'd0),
      .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_type(spawn_type),
      .spawn_time(spawn_time), .judge_valid(judge_valid), .judge_code(judge_code),
      .hold_active(hold_active), .song_time(song_time), .done(done)
   );

   note_lane_scheduler #(.NOTE_COUNT(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .start(start), .frame_tick(frame_tick), .key_down(key_down),
      .rom_addr(rom_addr1), .key_1(key_1b), .key_2(16'd0), .key_3(16'd0), .key_4(16'd0),
      .spawn_valid(spawn_valid1), .spawn_ready(spawn_ready), .spawn_type(spawn_type1),
      .spawn_time(spawn_time1), .judge_valid(judge_valid1), .judge_code(judge_code1),
      .hold_active(hold_active1), .song_time(song_time1), .done(done1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic load_chart(input logic [15:0] e0, input logic [15:0] e1, input int n0);
      for (int i = 0; i < 256; i++) chart[i] = 16'h3FFF;
      for (int i = 0; i < n0; i++) chart[i] = e0;
      chart[n0] = e1;
   endtask

   task automatic begin_song();
      key_down = 1'b0;
      Reset = 1'b1;
      cyc();
      cyc();
      Reset = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic do_frame(input logic key_lvl);
      f_spawns = 0; f_jv = 1'b0; f_jc = 2'b11; f_js = '0; f_st = '0; f_ss = '0; f_sty = 2'b11;
      for (int i = 0; i < 20; i++) begin
         frame_tick = (i == 0);
         if (i == 2) key_down = key_lvl;
         if (spawn_valid && spawn_ready) begin
            if (f_spawns == 0) begin
               f_st = spawn_time; f_ss = song_time; f_sty = spawn_type;
            end
            f_spawns++;
         end
         if (judge_valid) begin
            f_jv = 1'b1; f_jc = judge_code; f_js = song_time;
         end
         cyc();
      end
   endtask

   task automatic run_frames(input int n, input logic key_lvl);
      r_spawns = 0; r_judges = 0;
      for (int k = 0; k < n; k++) begin
         do_frame(key_lvl);
         r_spawns += f_spawns;
         r_judges += int'(f_jv);
      end
   endtask

   task automatic wait_spawn_valid();
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (spawn_valid) seen = 1'b1;
         else cyc();
      end
   endtask

   initial begin
      Reset = 1'b1; start = 1'b0; frame_tick = 1'b0; key_down = 1'b0; spawn_ready = 1'b1;
      load_chart(16'h0005, 16'h3FFF, 1);
      cyc();
      cyc();
      check("reset_spawn_valid", spawn_valid, 0);
      check("reset_judge_valid", judge_valid, 0);
      check("reset_song_time", song_time, 0);
      check("reset_done", done, 0);
      check("reset_rom_addr", rom_addr, 0);

      // Single tap at 5: spawned at frame 1, perfect at frame 5, one-entry chart finishes.
      begin_song();
      do_frame(1'b0);
      check("t1_spawn_count", f_spawns, 1);
      check("t1_spawn_time", f_st, 5);
      check("t1_spawn_type", f_sty, 0);
      check("t1_spawn_at_song", f_ss, 1);
      run_frames(3, 1'b0);
      check("t1_no_early_judge", r_judges, 0);
      check("t1_song_time_4", song_time, 4);
      do_frame(1'b1);
      check("t1_judge_seen", f_jv, 1);
      check("t1_judge_perfect", f_jc, 2'b10);
      check("t1_judge_song", f_js, 5);
      check("t1_done_one_entry", done1, 1);
      check("t1_not_done_more_entries", done, 0);

      // Tap at 20: early press discarded, press at 25 good.
      load_chart(16'h0014, 16'h3FFF, 1);
      begin_song();
      run_frames(9, 1'b0);
      do_frame(1'b1);
      check("t2_early_press_discarded", f_jv, 0);
      run_frames(14, 1'b0);
      check("t2_no_judge_11_24", r_judges, 0);
      do_frame(1'b1);
      check("t2_good_code", f_jc, 2'b01);
      check("t2_good_song", f_js, 25);

      // Same tap, never pressed: -6 still pending, -7 is a miss.
      begin_song();
      run_frames(26, 1'b0);
      check("t2_no_judge_to_26", r_judges, 0);
      do_frame(1'b0);
      check("t2_miss_seen", f_jv, 1);
      check("t2_miss_code", f_jc, 2'b00);
      check("t2_miss_song", f_js, 27);

      // Hold 10..30 held through: perfect start, perfect end.
      load_chart(16'h400A, 16'h801E, 1);
      begin_song();
      run_frames(9, 1'b0);
      check("t3_hold_spawns", r_spawns, 2);
      do_frame(1'b1);
      check("t3_start_perfect", f_jc, 2'b10);
      check("t3_start_song", f_js, 10);
      check("t3_hold_active_on", hold_active, 1);
      run_frames(19, 1'b1);
      check("t3_no_judge_mid_hold", r_judges, 0);
      do_frame(1'b1);
      check("t3_end_perfect", f_jc, 2'b10);
      check("t3_end_song", f_js, 30);
      check("t3_hold_active_off", hold_active, 0);

      // Same hold released at 18: miss, hold dropped.
      begin_song();
      run_frames(9, 1'b0);
      do_frame(1'b1);
      check("t3b_start_perfect", f_jc, 2'b10);
      run_frames(7, 1'b1);
      do_frame(1'b0);
      check("t3b_release_miss_seen", f_jv, 1);
      check("t3b_release_miss_code", f_jc, 2'b00);
      check("t3b_release_song", f_js, 18);
      check("t3b_hold_active_off", hold_active, 0);

      // Six taps at 2: spawn cap of 4 per frame.
      load_chart(16'h0002, 16'h3FFF, 6);
      begin_song();
      do_frame(1'b0);
      check("t4_frame1_spawns", f_spawns, 4);
      do_frame(1'b0);
      check("t4_frame2_spawns", f_spawns, 2);

      // Stalled spawn stays stable; two back-to-back ticks advance the song by 2.
      begin_song();
      spawn_ready = 1'b0;
      frame_tick = 1'b1;
      cyc();
      cyc();
      frame_tick = 1'b0;
      wait_spawn_valid();
      check("t5_stall_spawn_seen", seen, 1);
      for (int i = 0; i < 5; i++) begin
         check("t4_stall_stable", {spawn_valid, spawn_type, spawn_time}, {1'b1, 2'b00, 14'd2});
         cyc();
      end
      check("t5_stall_song_time", song_time, 1);
      spawn_ready = 1'b1;
      repeat (60) cyc();
      check("t5_two_ticks", song_time, 2);

      // Three back-to-back ticks: the third is dropped.
      begin_song();
      spawn_ready = 1'b0;
      frame_tick = 1'b1;
      cyc();
      cyc();
      cyc();
      frame_tick = 1'b0;
      repeat (5) cyc();
      spawn_ready = 1'b1;
      repeat (60) cyc();
      check("t5_three_ticks", song_time, 2);

      // Reset while a spawn is waiting for the renderer.
      begin_song();
      spawn_ready = 1'b0;
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      wait_spawn_valid();
      check("t6_spawn_pending", seen, 1);
      Reset = 1'b1;
      cyc();
      Reset = 1'b0;
      check("t6_outputs_cleared",
            {spawn_valid, spawn_type, spawn_time, judge_valid, judge_code, hold_active, done, rom_addr},
            '0);
      check("t6_song_time", song_time, 0);
      spawn_ready = 1'b1;
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      repeat (10) cyc();
      check("t6_idle_ignores_tick", song_time, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1);
   end

endmodule
